// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch stage: FSM state encoding, next-PC
// select codes and the default reset vector.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_JUMP    = 2'd0,
    SEL_BRANCH  = 2'd1,
    SEL_PENDING = 2'd2,
    SEL_INC     = 2'd3
  } next_sel_t;

  localparam int unsigned DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/pc_fetch_unit_next_mux.sv
// Combinational next-PC priority selector: jump, then branch, then the
// buffered redirect, then the incrementer result.
module pc_next_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             pending,
  input  logic [WIDTH-1:0] pending_target,
  input  logic [WIDTH-1:0] pc_now,
  output logic [WIDTH-1:0] next_pc,
  output next_sel_t        sel
);

  always_comb begin
    next_pc = pc_now;
    sel     = SEL_INC;
    if (jump) begin
      next_pc = jump_target;
      sel     = SEL_JUMP;
    end else if (branch) begin
      next_pc = branch_target;
      sel     = SEL_BRANCH;
    end else if (pending) begin
      next_pc = pending_target;
      sel     = SEL_PENDING;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: BOOT/RUN/HALTED control, PC register, buffering of
// redirects that arrive while fetch is blocked, and an advance counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCNow,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] PCOut,
  output logic             imem_req,
  output logic             halted,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] adv_count
);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [WIDTH-1:0] pending_target;
  logic [WIDTH-1:0] next_pc;
  next_sel_t        next_sel;
  logic             advance;
  logic             capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = Halt ? HALTED : RUN;
      RUN:     state_d = Halt ? HALTED : RUN;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req = (state_q == RUN);
    halted   = (state_q == HALTED);
  end

  pc_next_mux #(.WIDTH(WIDTH)) u_next_mux (
    .jump           (Jump),
    .jump_target    (JumpTarget),
    .branch         (Branch),
    .branch_target  (BranchTarget),
    .pending        (redirect_pending),
    .pending_target (pending_target),
    .pc_now         (PCNow),
    .next_pc        (next_pc),
    .sel            (next_sel)
  );

  // The mux already ranks jump over branch, so its output is the target to buffer.
  assign advance = (state_q == RUN) && imem_ready && !Stall && !Halt;
  assign capture = (state_q == RUN) && !Halt &&
                   ((next_sel == SEL_JUMP) || (next_sel == SEL_BRANCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          PCOut <= RESET_VEC;
    else if (advance) PCOut <= next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end else if (advance) begin
      redirect_pending <= 1'b0;
    end else if (capture) begin
      redirect_pending <= 1'b1;
      pending_target   <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          adv_count <= '0;
    else if (advance) adv_count <= adv_count + 1'b1;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expectations are queued with each
// stimulus step and popped against the DUT outputs on the falling edge.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        req;
    logic        hlt;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcnow;
  logic        branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        imem_ready = 1'b1;
  logic [31:0] pcout;
  logic        imem_req;
  logic        halted;
  logic        redirect_pending;
  logic [31:0] adv_count;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  // The incrementer upstream: wraps naturally at 32 bits.
  assign pcnow = pcout + 32'd1;

  pc_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .PCNow            (pcnow),
    .Branch           (branch),
    .BranchTarget     (branch_target),
    .Jump             (jump),
    .JumpTarget       (jump_target),
    .Stall            (stall),
    .Halt             (halt),
    .imem_ready       (imem_ready),
    .PCOut            (pcout),
    .imem_req         (imem_req),
    .halted           (halted),
    .redirect_pending (redirect_pending),
    .adv_count        (adv_count)
  );

  task automatic expectOut(input string tag, input logic [31:0] pc, input logic req,
                           input logic hlt, input logic pend, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.req = req; e.hlt = hlt; e.pend = pend; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "PCOut", pcout, e.pc);
    cmp(e.tag, "imem_req", {31'd0, imem_req}, {31'd0, e.req});
    cmp(e.tag, "halted", {31'd0, halted}, {31'd0, e.hlt});
    cmp(e.tag, "redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
    cmp(e.tag, "adv_count", adv_count, e.cnt);
  endtask

  task automatic applyStimulus(input logic j, input logic [31:0] jt, input logic b,
                               input logic [31:0] bt, input logic st, input logic h,
                               input logic rdy);
    jump = j; jump_target = jt; branch = b; branch_target = bt;
    stall = st; halt = h; imem_ready = rdy;
  endtask

  task automatic stepAndCheck();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    #3;
    expectOut("reset", 32'(DEFAULT_RESET_VEC), 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput();

    @(negedge clk);
    rst = 1'b0;
    #1;
    expectOut("boot", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput();
    @(negedge clk);
    expectOut("run_first_fetch", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput();
    for (int i = 1; i <= 5; i++) begin
      expectOut($sformatf("seq_pc%0d", i), 32'(i), 1'b1, 1'b0, 1'b0, 32'(i));
      stepAndCheck();
    end

    applyStimulus(1'b0, '0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    expectOut("branch", 32'h40, 1'b1, 1'b0, 1'b0, 32'd6);
    stepAndCheck();
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h90, 1'b0, 1'b0, 1'b1);
    expectOut("jump_over_branch", 32'h80, 1'b1, 1'b0, 1'b0, 32'd7);
    stepAndCheck();
    applyStimulus(1'b1, 32'd7, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    expectOut("jump_to7", 32'd7, 1'b1, 1'b0, 1'b0, 32'd8);
    stepAndCheck();

    applyStimulus(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    expectOut("buf_jump", 32'd7, 1'b1, 1'b0, 1'b1, 32'd8);
    stepAndCheck();
    idle(1'b0);
    expectOut("buf_wait", 32'd7, 1'b1, 1'b0, 1'b1, 32'd8);
    stepAndCheck();
    applyStimulus(1'b0, '0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    expectOut("buf_branch", 32'd7, 1'b1, 1'b0, 1'b1, 32'd8);
    stepAndCheck();
    idle(1'b1);
    expectOut("buf_release", 32'h200, 1'b1, 1'b0, 1'b0, 32'd9);
    stepAndCheck();

    applyStimulus(1'b1, 32'd9, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    expectOut("jump_to9", 32'd9, 1'b1, 1'b0, 1'b0, 32'd10);
    stepAndCheck();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      expectOut($sformatf("stall%0d", i), 32'd9, 1'b1, 1'b0, 1'b0, 32'd10);
      stepAndCheck();
    end
    idle(1'b1);
    expectOut("unstall", 32'd10, 1'b1, 1'b0, 1'b0, 32'd11);
    stepAndCheck();
    expectOut("seq_pc11", 32'd11, 1'b1, 1'b0, 1'b0, 32'd12);
    stepAndCheck();
    expectOut("seq_pc12", 32'd12, 1'b1, 1'b0, 1'b0, 32'd13);
    stepAndCheck();

    applyStimulus(1'b1, 32'h300, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    expectOut("halt_jump", 32'd12, 1'b0, 1'b1, 1'b0, 32'd13);
    stepAndCheck();
    applyStimulus(1'b0, '0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    expectOut("halted_branch", 32'd12, 1'b0, 1'b1, 1'b0, 32'd13);
    stepAndCheck();
    idle(1'b1);
    expectOut("halted_sticky", 32'd12, 1'b0, 1'b1, 1'b0, 32'd13);
    stepAndCheck();

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expectOut("halt_reset", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    #1;
    expectOut("boot2", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput();
    @(negedge clk);
    expectOut("run2", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput();

    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    expectOut("jump_allones", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd1);
    stepAndCheck();
    idle(1'b1);
    expectOut("pc_wrap", 32'd0, 1'b1, 1'b0, 1'b0, 32'd2);
    stepAndCheck();
    applyStimulus(1'b0, '0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    expectOut("pend_before_rst", 32'd0, 1'b1, 1'b0, 1'b1, 32'd2);
    stepAndCheck();

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expectOut("async_reset", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
